// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, one 32-bit word per bus beat.
// Define LSU_MISALIGNED_EN to split word-crossing accesses into two beats.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        access_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t      state;
    logic        store_q;
    logic        split_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [3:0]  hi_strb;
    logic [31:0] hi_wdata;
    logic [31:0] lo_word;

    logic        half;
    logic        word;
    logic        size_ok;
    logic        align_ok;
    logic        legal;
    logic        split;
    logic [7:0]  st_strb;
    logic [63:0] st_data;
    logic [63:0] ld_cat;
    logic [31:0] ld_sel;
    logic [31:0] ld_ext;

    always_comb begin
        half    = (funct3[1:0] == 2'b01);
        word    = (funct3[1:0] == 2'b10);
        size_ok = is_store ? (funct3 <= 3'b010)
                           : (funct3 != 3'b011 && funct3[2:1] != 2'b11);
`ifdef LSU_MISALIGNED_EN
        align_ok = 1'b1;
        split    = (half && addr[1:0] == 2'b11)
                || (word && addr[1:0] != 2'b00);
`else
        align_ok = !(half && addr[0])
                && !(word && addr[1:0] != 2'b00);
        split    = 1'b0;
`endif
        legal = size_ok && align_ok;
    end

    // Lanes are laid out over two words; the upper word is used only by split accesses.
    always_comb begin
        st_strb = 8'h00;
        st_data = 64'h0;
        case (funct3[1:0])
            2'b00: begin
                st_strb = 8'b0000_0001 << addr[1:0];
                st_data = {32'h0, {4{wdata[7:0]}}};
            end
            2'b01: begin
                st_strb = 8'b0000_0011 << addr[1:0];
                st_data = {48'h0, wdata[15:0]} << {addr[1:0], 3'b000};
            end
            2'b10: begin
                st_strb = 8'b0000_1111 << addr[1:0];
                st_data = {32'h0, wdata} << {addr[1:0], 3'b000};
            end
            default: begin
                st_strb = 8'h00;
                st_data = 64'h0;
            end
        endcase
    end

    always_comb begin
        ld_cat = (state == BEAT1) ? {bus_rdata, lo_word}
                                  : {32'h0, bus_rdata};
        ld_sel = 32'(ld_cat >> {off_q, 3'b000});
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_sel[7]}}, ld_sel[7:0]};
            3'b001:  ld_ext = {{16{ld_sel[15]}}, ld_sel[15:0]};
            3'b100:  ld_ext = {24'h0, ld_sel[7:0]};
            3'b101:  ld_ext = {16'h0, ld_sel[15:0]};
            default: ld_ext = ld_sel;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            rdata      <= 32'h0;
            access_err <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_wstrb  <= 4'h0;
            bus_wdata  <= 32'h0;
            store_q    <= 1'b0;
            split_q    <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            hi_strb    <= 4'h0;
            hi_wdata   <= 32'h0;
            lo_word    <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        store_q   <= is_store;
                        funct3_q  <= funct3;
                        off_q     <= addr[1:0];
                        split_q   <= split;
                        if (legal) begin
                            state     <= BEAT0;
                            bus_req   <= 1'b1;
                            bus_we    <= is_store;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wstrb <= is_store ? st_strb[3:0] : 4'h0;
                            bus_wdata <= is_store ? st_data[31:0] : 32'h0;
                            hi_strb   <= is_store ? st_strb[7:4] : 4'h0;
                            hi_wdata  <= is_store ? st_data[63:32] : 32'h0;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            access_err <= 1'b1;
                            rdata      <= 32'h0;
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (bus_ack) begin
                        if (state == BEAT0 && split_q) begin
                            state     <= BEAT1;
                            lo_word   <= bus_rdata;
                            bus_addr  <= bus_addr + 32'd4;
                            bus_wstrb <= hi_strb;
                            bus_wdata <= hi_wdata;
                        end else begin
                            state      <= RESP;
                            bus_req    <= 1'b0;
                            bus_we     <= 1'b0;
                            bus_addr   <= 32'h0;
                            bus_wstrb  <= 4'h0;
                            bus_wdata  <= 32'h0;
                            resp_valid <= 1'b1;
                            access_err <= 1'b0;
                            rdata      <= store_q ? 32'h0 : ld_ext;
                        end
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    access_err <= 1'b0;
                    rdata      <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory responder and scoreboard.
// Expectations follow LSU_MISALIGNED_EN when it is defined for the build.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        access_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:1023];
    int          checks = 0;
    int          failures = 0;
    int          beats, ack_idx, resp_idx, wait_cnt;
    logic        in_beat, leak, unstable;
    logic [31:0] first_addr, last_addr, first_wdata, last_wdata;
    logic [3:0]  first_strb, last_strb;
    logic        first_we;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .access_err (access_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] idx(input logic [31:0] a);
        return a[11:2];
    endfunction

    // Issue one request, answer bus beats after lat cycles, check the response.
    task automatic run(input string name, input logic st,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int lat,
                       input logic [31:0] er, input logic ee);
        exp_t e;
        beats = 0; ack_idx = -1; resp_idx = -1;
        in_beat = 0; leak = 0; unstable = 0; wait_cnt = 0;
        chk({name, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        e.rdata = er; e.err = ee;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 40 && resp_idx < 0; i++) begin
            bus_ack = 1'b0;
            if (resp_valid) begin
                resp_idx = i;
                if (sb.size() == 0) begin
                    chk({name, ".sb_underflow"}, 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk({name, ".rdata"}, rdata, e.rdata);
                    chk({name, ".access_err"}, 32'(access_err), 32'(e.err));
                end
            end else begin
                if (rdata !== 32'h0 || access_err !== 1'b0) leak = 1'b1;
                if (bus_req) begin
                    if (!in_beat) begin
                        in_beat = 1'b1; wait_cnt = 0; beats++;
                        if (beats == 1) begin
                            first_addr = bus_addr; first_strb = bus_wstrb;
                            first_wdata = bus_wdata; first_we = bus_we;
                        end
                        last_addr = bus_addr; last_strb = bus_wstrb;
                        last_wdata = bus_wdata;
                    end else if (bus_addr !== last_addr
                              || bus_wstrb !== last_strb
                              || bus_wdata !== last_wdata) begin
                        unstable = 1'b1;
                    end
                    if (wait_cnt == lat) begin
                        bus_ack = 1'b1;
                        bus_rdata = mem[idx(bus_addr)];
                        ack_idx = i; in_beat = 1'b0;
                        if (bus_we)
                            for (int b = 0; b < 4; b++)
                                if (bus_wstrb[b])
                                    mem[idx(bus_addr)][8*b +: 8] = bus_wdata[8*b +: 8];
                    end else begin
                        wait_cnt++;
                    end
                end
                @(negedge clk);
            end
        end
        bus_ack = 1'b0;
        chk({name, ".resp_seen"}, 32'(resp_idx >= 0), 32'd1);
        chk({name, ".quiet_outs"}, 32'(leak), 32'd0);
        chk({name, ".bus_stable"}, 32'(unstable), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[idx(32'h100)] = 32'hDEADBEEF;
        mem[idx(32'h200)] = 32'h11112222;
        mem[idx(32'h300)] = 32'h44332211;
        mem[idx(32'h304)] = 32'h88776655;
        rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.bus_req", 32'(bus_req), 32'd0);
        chk("rst.bus_addr", bus_addr, 32'h0);
        chk("rst.bus_data", {bus_wdata[27:0], bus_wstrb}, 32'h0);
        chk("rst.rdata", rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.ready", 32'(req_ready), 32'd1);
        chk("post_rst.outs",
            32'({resp_valid, access_err, bus_req, bus_we, bus_wstrb}), 32'd0);

        run("lw", 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0);
        chk("lw.beats", beats, 32'd1);
        chk("lw.bus_addr", first_addr, 32'h100);
        chk("lw.we_strb", 32'({first_we, first_strb}), 32'd0);
        chk("lw.ack_to_resp", resp_idx - ack_idx, 32'd1);

        mem[idx(32'h100)] = 32'h80FF0000;
        run("lb", 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'hFFFFFF80, 1'b0);
        chk("lb.min_latency", resp_idx, 32'd1);
        run("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h00000080, 1'b0);

        run("sh", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'h0, 1'b0);
        chk("sh.strb", 32'(first_strb), 32'b1100);
        chk("sh.wdata_hi", 32'(first_wdata[31:16]), 32'hABCD);
        chk("sh.we", 32'(first_we), 32'd1);
        chk("sh.bus_addr", first_addr, 32'h200);
        chk("sh.beats", beats, 32'd1);
        run("lw_after_sh", 1'b0, 3'b010, 32'h200, 32'h0, 0, 32'hABCD2222, 1'b0);

        run("sb", 1'b1, 3'b000, 32'h201, 32'h0000005A, 0, 32'h0, 1'b0);
        chk("sb.strb", 32'(last_strb), 32'b0010);
        chk("sb.wdata", first_wdata, 32'h5A5A5A5A);
        run("lhu", 1'b0, 3'b101, 32'h200, 32'h0, 0, 32'h00005A22, 1'b0);
        run("lh", 1'b0, 3'b001, 32'h202, 32'h0, 0, 32'hFFFFABCD, 1'b0);

`ifdef LSU_MISALIGNED_EN
        run("lw_mis", 1'b0, 3'b010, 32'h301, 32'h0, 1, 32'h55443322, 1'b0);
        chk("lw_mis.beats", beats, 32'd2);
        chk("lw_mis.addr0", first_addr, 32'h300);
        chk("lw_mis.addr1", last_addr, 32'h304);
        chk("lw_mis.ack_to_resp", resp_idx - ack_idx, 32'd1);
        run("lh_o1", 1'b0, 3'b001, 32'h201, 32'h0, 0, 32'hFFFFCD5A, 1'b0);
        chk("lh_o1.beats", beats, 32'd1);
        run("sw_mis", 1'b1, 3'b010, 32'h306, 32'hCAFEF00D, 0, 32'h0, 1'b0);
        chk("sw_mis.strb0", 32'(first_strb), 32'b1100);
        chk("sw_mis.strb1", 32'(last_strb), 32'b0011);
        chk("sw_mis.wdata0", first_wdata, 32'hF00D0000);
        chk("sw_mis.wdata1", last_wdata, 32'h0000CAFE);
        run("lw_mis2", 1'b0, 3'b010, 32'h306, 32'h0, 2, 32'hCAFEF00D, 1'b0);
`else
        run("lw_mis", 1'b0, 3'b010, 32'h301, 32'h0, 1, 32'h0, 1'b1);
        chk("lw_mis.beats", beats, 32'd0);
        chk("lw_mis.latency", resp_idx, 32'd0);
        run("lh_o1", 1'b0, 3'b001, 32'h201, 32'h0, 0, 32'h0, 1'b1);
        chk("lh_o1.beats", beats, 32'd0);
`endif

        run("ld_f111", 1'b0, 3'b111, 32'h100, 32'h0, 0, 32'h0, 1'b1);
        chk("ld_f111.beats", beats, 32'd0);
        chk("ld_f111.latency", resp_idx, 32'd0);
        run("st_f011", 1'b1, 3'b011, 32'h100, 32'hFFFFFFFF, 0, 32'h0, 1'b1);
        chk("st_f011.beats", beats, 32'd0);

        // Abandon a load while its beat is outstanding.
        chk("abort.ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort.bus_req", 32'(bus_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.rst_bus_req", 32'(bus_req), 32'd0);
        chk("abort.rst_ready", 32'(req_ready), 32'd1);
        chk("abort.rst_resp", 32'(resp_valid), 32'd0);
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h12345678;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("abort.post_outs",
            32'({resp_valid, access_err, bus_req, bus_we, bus_wstrb}), 32'd0);
        chk("abort.post_rdata", rdata, 32'h0);
        chk("abort.post_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("abort.late_ack_resp", 32'(resp_valid), 32'd0);

        run("lw_recover", 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h80FF0000, 1'b0);
        chk("sb.empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
